// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the shared-memory datapath strobes; illegal opcodes park the core in TRAP.
module multicycle_control_unit #(
    parameter int unsigned ALUOP_W       = 4,
    parameter int unsigned USE_MEM_READY = 0,
    parameter int unsigned MEM_LAT       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               mem_ready,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               ALUSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               Jal,
    output logic               Jalr,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               instr_done,
    output logic               illegal_instr,
    output logic [2:0]         state
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_BR    = 4'd2;
    localparam logic [3:0] ALU_RTYPE = 4'd3;
    localparam logic [3:0] ALU_IALU  = 4'd4;
    localparam logic [3:0] ALU_LUI   = 4'd5;
    localparam logic [3:0] ALU_AUIPC = 4'd6;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_done;
    logic             valid_op;
    logic             illegal_q;

    // funct3/funct7 are decoded by the downstream ALU decoder, not here
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7};

    assign mem_done = (USE_MEM_READY != 0) ? mem_ready
                                           : (wait_cnt == CNT_W'(MEM_LAT - 1));

    always_comb begin
        valid_op = 1'b0;
        case (opcode)
            OP_RTYPE, OP_IALU, OP_LUI, OP_AUIPC, OP_LOAD,
            OP_STORE, OP_BR, OP_JAL, OP_JALR: valid_op = 1'b1;
            default:                          valid_op = 1'b0;
        endcase
    end

    // State register, memory wait counter and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            illegal_q <= illegal_q | (nxt_state == S_TRAP);
            if ((USE_MEM_READY == 0) && !mem_done &&
                ((cur_state == S_FETCH) || (cur_state == S_MEM)))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH:  nxt_state = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: nxt_state = valid_op ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (opcode == OP_BR)
                    nxt_state = S_FETCH;
                else if ((opcode == OP_LOAD) || (opcode == OP_STORE))
                    nxt_state = S_MEM;
                else
                    nxt_state = S_WB;
            end
            S_MEM: begin
                if (mem_done)
                    nxt_state = (opcode == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:     nxt_state = S_FETCH;
            S_TRAP:   nxt_state = S_TRAP;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state and instruction class
    always_comb begin
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        Jal        = 1'b0;
        Jalr       = 1'b0;
        ALUOp      = '0;
        instr_done = 1'b0;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_done;
                PCWrite = mem_done;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: ALUOp = ALUOP_W'(ALU_RTYPE);
                    OP_IALU: begin
                        ALUOp  = ALUOP_W'(ALU_IALU);
                        ALUSrc = 1'b1;
                    end
                    OP_LUI: begin
                        ALUOp  = ALUOP_W'(ALU_LUI);
                        ALUSrc = 1'b1;
                    end
                    OP_AUIPC: begin
                        ALUOp  = ALUOP_W'(ALU_AUIPC);
                        ALUSrc = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUOp  = ALUOP_W'(ALU_ADD);
                        ALUSrc = 1'b1;
                    end
                    OP_BR: begin
                        Branch     = 1'b1;
                        ALUOp      = ALUOP_W'(ALU_BR);
                        instr_done = 1'b1;
                    end
                    OP_JAL: begin
                        Jal     = 1'b1;
                        PCWrite = 1'b1;
                    end
                    OP_JALR: begin
                        Jalr    = 1'b1;
                        PCWrite = 1'b1;
                        ALUSrc  = 1'b1;
                        ALUOp   = ALUOP_W'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                IorD   = 1'b1;
                ALUSrc = 1'b1;
                ALUOp  = ALUOP_W'(ALU_ADD);
                if (opcode == OP_LOAD) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite   = 1'b1;
                    instr_done = mem_done;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                MemtoReg   = (opcode == OP_LOAD);
            end
            default: ;
        endcase
    end

    assign illegal_instr = illegal_q;
    assign state         = cur_state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM; successor to the single-cycle control_unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes per state.
- Supports a parametrised fixed-latency memory or a mem_ready handshake, and traps on illegal opcodes.
- Sits between the instruction register (opcode/funct3/funct7) and the shared-memory multi-cycle datapath.

Parameters:
- ALUOP_W, 4, width of ALUOp.
- USE_MEM_READY, 0: 0 = fixed latency MEM_LAT; 1 = wait for mem_ready.
- MEM_LAT, 1, memory access cycles when USE_MEM_READY=0; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- opcode  input  7  IR[6:0]; valid from DECODE onward, ignored in IDLE/FETCH
- funct3  input  3  IR[14:12]
- funct7  input  7  IR[31:25]
- mem_ready  input  1  access-complete strobe (used only if USE_MEM_READY=1)
- RegWrite  output  1  register file write enable
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- MemtoReg  output  1  WB source: 1 = memory data, 0 = ALUOut/PC+4
- ALUSrc  output  1  ALU B operand: 1 = immediate
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  output  1  latch fetched instruction
- PCWrite  output  1  unconditional PC update
- Branch  output  1  PC update qualified by the branch compare result
- Jal  output  1  JAL target select
- Jalr  output  1  JALR target select
- ALUOp  output  ALUOP_W  ALU control class
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_instr  output  1  sticky trap flag
- state  output  3  current state, for debug

Behaviour:
- Reset: rst is sampled on the clk edge and overrides everything, including mid-access. Next state is IDLE; the wait counter and illegal_instr clear. In IDLE all outputs are 0 and state=0. IDLE always moves to FETCH on the next cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- ALUOp encoding: 0000 ADD, 0001 SUB, 0010 BRANCH (ALU uses funct3), 0011 R-type (funct3/funct7), 0100 I-type ALU, 0101 LUI pass-B, 0110 AUIPC (PC+imm).
- Memory done:
  - USE_MEM_READY=1: done = mem_ready in the current cycle.
  - USE_MEM_READY=0: a counter clears on entry to FETCH or MEM; done when count == MEM_LAT-1.
  - MemRead/MemWrite/IorD stay stable for the whole wait.
- FETCH: MemRead=1, IorD=0.
  - Not done: stay in FETCH.
  - Done: IRWrite=1 and PCWrite=1 (PC+4) in the same cycle, then DECODE. The datapath keeps old_pc.
- DECODE: all strobes 0.
  - Valid opcodes: 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111. Any valid opcode goes to EXEC.
  - Any other opcode goes to TRAP.
- EXEC:
  - R-type: ALUOp=0011, ALUSrc=0, then WB.
  - I-ALU: ALUOp=0100, ALUSrc=1, then WB.
  - LUI: ALUOp=0101, ALUSrc=1, then WB.
  - AUIPC: ALUOp=0110, ALUSrc=1, then WB.
  - Load/store: ALUOp=0000, ALUSrc=1, then MEM.
  - Branch: Branch=1, ALUOp=0010, ALUSrc=0, instr_done=1, then FETCH.
  - JAL: Jal=1, PCWrite=1, then WB.
  - JALR: Jalr=1, PCWrite=1, ALUSrc=1, ALUOp=0000, then WB.
- MEM: IorD=1, ALUOp=0000, ALUSrc=1.
  - Load: MemRead=1; waits for done, then WB.
  - Store: MemWrite=1; waits for done; instr_done=1 on the done cycle, then FETCH.
- WB: RegWrite=1, instr_done=1, then FETCH.
  - MemtoReg=1 for loads, 0 otherwise.
  - JAL/JALR write PC+4.
- TRAP: illegal_instr=1, all other outputs 0. Stays in TRAP until rst.
- Cycle counts with MEM_LAT=1 or mem_ready always 1: branch 3, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5. Each memory wait cycle adds one.
- funct3/funct7 are not decoded here; they are forwarded via the ALUOp class to the ALU decoder.

Test Plan:
- USE_MEM_READY=0, MEM_LAT=1, opcode=0110011 after IR load -> state sequence 0,1,2,3,5,1. RegWrite=1 only in WB. ALUOp=0011 in EXEC. instr_done pulses once; 4 cycles per instruction.
- opcode=0000011, MEM_LAT=3 -> FETCH holds MemRead=1, IorD=0 for 3 cycles, with IRWrite and PCWrite in the 3rd only. MEM holds MemRead=1, IorD=1 for 3 cycles. WB has RegWrite=1, MemtoReg=1. Total 9 cycles.
- USE_MEM_READY=1, opcode=0100011, mem_ready low for 4 cycles in MEM -> MemWrite held 5 cycles. instr_done pulses on the mem_ready cycle. Next state FETCH. RegWrite stays 0 throughout.
- opcode=1100011 -> EXEC has Branch=1, ALUOp=0010, ALUSrc=0. Returns to FETCH after 3 cycles, no WB. opcode=1101111 -> EXEC has Jal=1, PCWrite=1, then WB has RegWrite=1, MemtoReg=0.
- opcode=0000000 in DECODE -> TRAP (state=6), illegal_instr=1 and held for 20 cycles with all strobes 0. Assert rst for 1 cycle -> IDLE with outputs 0 and illegal_instr=0, then FETCH.
- Assert rst during a MEM wait with MEM_LAT=3, load in flight -> next cycle IDLE, MemRead=0, counter cleared. Next fetch takes the full 3 cycles.
